// File: rtl/bus_wait_ctrl.sv
// Wait-state sequencer: stalls the 6502 via RDY for a fixed count on ROM/IO cycles,
// or for the duration of a req/ack handshake with the SDRAM controller.
module bus_wait_ctrl #(
    parameter int CNT_W         = 5,
    parameter int ROM_WAIT      = 1,
    parameter int IO_WAIT       = 2,
    parameter int SDRAM_TIMEOUT = 31
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cycle_start,
    input  logic i_rwb,
    input  logic i_rom_cs,
    input  logic i_io_cs,
    input  logic i_sdram_cs,
    input  logic i_sdram_ack,
    output logic o_rdy,
    output logic o_sdram_req,
    output logic o_sdram_we,
    output logic o_busy,
    output logic o_timeout
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIXED = 2'd1,
        SDRAM_REQ  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ROM_CNT  = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] IO_CNT   = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] SD_CNT   = CNT_W'(SDRAM_TIMEOUT);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             rdy_r, rdy_s;
    logic             req_r, req_s;
    logic             we_r, we_s;
    logic             busy_r;
    logic             timeout_r, timeout_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rdy_s     = rdy_r;
        req_s     = req_r;
        we_s      = we_r;
        timeout_s = timeout_r;
        case (state_r)
            IDLE: begin
                rdy_s = 1'b1;
                req_s = 1'b0;
                we_s  = 1'b0;
                cnt_s = CNT_ZERO;
                if (i_cycle_start) begin
                    // Region priority: sdram > io > rom; a zero-wait region never leaves IDLE.
                    if (i_sdram_cs) begin
                        state_s = SDRAM_REQ;
                        cnt_s   = SD_CNT;
                        req_s   = 1'b1;
                        we_s    = ~i_rwb;
                        rdy_s   = 1'b0;
                    end else if (i_io_cs) begin
                        if (IO_CNT != CNT_ZERO) begin
                            state_s = WAIT_FIXED;
                            cnt_s   = IO_CNT;
                            rdy_s   = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (i_rom_cs) begin
                        if (ROM_CNT != CNT_ZERO) begin
                            state_s = WAIT_FIXED;
                            cnt_s   = ROM_CNT;
                            rdy_s   = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_FIXED: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    rdy_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                    rdy_s = 1'b0;
                end
            end
            SDRAM_REQ: begin
                // Ack takes precedence over an expiring timeout in the same cycle.
                if (i_sdram_ack) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    req_s   = 1'b0;
                    we_s    = 1'b0;
                    rdy_s   = 1'b1;
                end else if (cnt_r == CNT_ONE) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    req_s     = 1'b0;
                    we_s      = 1'b0;
                    rdy_s     = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                rdy_s   = 1'b1;
                req_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            rdy_r     <= 1'b1;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rdy_r     <= rdy_s;
            req_r     <= req_s;
            we_r      <= we_s;
            busy_r    <= (state_s != IDLE);
            timeout_r <= timeout_s;
        end
    end

    assign o_rdy       = rdy_r;
    assign o_sdram_req = req_r;
    assign o_sdram_we  = we_r;
    assign o_busy      = busy_r;
    assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Scoreboard bench for bus_wait_ctrl: each driven cycle pushes the expected output word
// {rdy, req, we, busy, timeout} for the next cycle, which is popped and compared after the edge.
module tb_bus_wait_ctrl;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_cycle_start = 1'b0;
    logic i_rwb = 1'b1;
    logic i_rom_cs = 1'b0;
    logic i_io_cs = 1'b0;
    logic i_sdram_cs = 1'b0;
    logic i_sdram_ack = 1'b0;
    logic o_rdy, o_sdram_req, o_sdram_we, o_busy, o_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    logic to_exp = 1'b0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    bus_wait_ctrl #(
        .CNT_W(5), .ROM_WAIT(1), .IO_WAIT(3), .SDRAM_TIMEOUT(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cycle_start(i_cycle_start), .i_rwb(i_rwb),
        .i_rom_cs(i_rom_cs), .i_io_cs(i_io_cs), .i_sdram_cs(i_sdram_cs),
        .i_sdram_ack(i_sdram_ack), .o_rdy(o_rdy), .o_sdram_req(o_sdram_req),
        .o_sdram_we(o_sdram_we), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    function automatic logic [4:0] ex(input logic rdy, input logic req, input logic we,
                                      input logic busy);
        return {rdy, req, we, busy, to_exp};
    endfunction

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got rdy/req/we/busy/to=%b expected %b", tag, got, want);
    endtask

    // Push expectation for the cycle after this edge, advance, then pop and compare.
    task automatic cyc(input string tag, input logic [4:0] e);
        logic [4:0] w;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge i_clk);
        #1;
        w = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {o_rdy, o_sdram_req, o_sdram_we, o_busy, o_timeout}, w);
        i_cycle_start = 1'b0;
        i_rom_cs = 1'b0;
        i_io_cs = 1'b0;
        i_sdram_cs = 1'b0;
        i_sdram_ack = 1'b0;
        i_rst = 1'b0;
    endtask

    task automatic start(input logic rom, input logic io, input logic sd, input logic rwb);
        i_cycle_start = 1'b1;
        i_rom_cs = rom;
        i_io_cs = io;
        i_sdram_cs = sd;
        i_rwb = rwb;
    endtask

    initial begin
        // Reset
        i_rst = 1'b1;
        cyc("reset0", ex(1'b1, 1'b0, 1'b0, 1'b0));
        i_rst = 1'b1;
        cyc("reset1", ex(1'b1, 1'b0, 1'b0, 1'b0));
        cyc("idle", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // ROM read, one wait state
        start(1'b1, 1'b0, 1'b0, 1'b1);
        cyc("rom_c1", ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("rom_c2", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // IO write, three wait states
        start(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) cyc($sformatf("io_c%0d", i), ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("io_c4", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // SDRAM write, ack during cycle 4
        start(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) cyc($sformatf("sdw_c%0d", i), ex(1'b0, 1'b1, 1'b1, 1'b1));
        i_sdram_ack = 1'b1;
        cyc("sdw_c5", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // SDRAM read acked on the first request cycle
        start(1'b0, 1'b0, 1'b1, 1'b1);
        cyc("sdr_ack_c1", ex(1'b0, 1'b1, 1'b0, 1'b1));
        i_sdram_ack = 1'b1;
        cyc("sdr_ack_c2", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // SDRAM read timing out after 8 cycles
        start(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) cyc($sformatf("sdto_c%0d", i), ex(1'b0, 1'b1, 1'b0, 1'b1));
        to_exp = 1'b1;
        cyc("sdto_c9", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // Timeout stays sticky across a good access
        start(1'b1, 1'b0, 1'b0, 1'b1);
        cyc("sticky_c1", ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("sticky_c2", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // Unmapped cycle and stray ack while idle
        start(1'b0, 1'b0, 1'b0, 1'b1);
        cyc("unmap_c1", ex(1'b1, 1'b0, 1'b0, 1'b0));
        i_sdram_ack = 1'b1;
        cyc("stray_ack", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // Start pulses while busy are ignored; back-to-back accepted after return to idle
        start(1'b0, 1'b1, 1'b0, 1'b1);
        cyc("busy_c1", ex(1'b0, 1'b0, 1'b0, 1'b1));
        start(1'b0, 1'b0, 1'b1, 1'b1);
        cyc("busy_c2", ex(1'b0, 1'b0, 1'b0, 1'b1));
        start(1'b1, 1'b0, 1'b0, 1'b1);
        cyc("busy_c3", ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("busy_c4", ex(1'b1, 1'b0, 1'b0, 1'b0));
        start(1'b1, 1'b0, 1'b0, 1'b1);
        cyc("b2b_c1", ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("b2b_c2", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // sdram_cs and io_cs together: SDRAM path wins
        start(1'b0, 1'b1, 1'b1, 1'b0);
        cyc("prio_c1", ex(1'b0, 1'b1, 1'b1, 1'b1));
        i_sdram_ack = 1'b1;
        cyc("prio_c2", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // Reset in cycle 2 of an IO access aborts it and clears timeout
        start(1'b0, 1'b1, 1'b0, 1'b1);
        cyc("rstmid_c1", ex(1'b0, 1'b0, 1'b0, 1'b1));
        cyc("rstmid_c2", ex(1'b0, 1'b0, 1'b0, 1'b1));
        i_rst = 1'b1;
        to_exp = 1'b0;
        cyc("rstmid_c3", ex(1'b1, 1'b0, 1'b0, 1'b0));
        cyc("rstmid_c4", ex(1'b1, 1'b0, 1'b0, 1'b0));

        // Ack on the final timeout cycle: ack wins, no timeout flagged
        start(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) cyc($sformatf("race_c%0d", i), ex(1'b0, 1'b1, 1'b0, 1'b1));
        i_sdram_ack = 1'b1;
        cyc("race_c9", ex(1'b1, 1'b0, 1'b0, 1'b0));
        cyc("race_c10", ex(1'b1, 1'b0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
